// File: rtl/bcd_score_counter.sv
// bcd_score_counter
//
// Multi-digit saturating BCD score counter with hit-streak bonus.
// Hit and miss are level inputs; each rising edge is one event. Once the
// streak of consecutive hits reaches BONUS_STREAK, every further hit scores 2.
// Misses decrement with BCD borrow and floor at zero. An add that carries out
// of the top digit pins the score at all 9s and sets the sticky saturated flag.
//
// Optional feature: define SCORE_HISCORE_EN to keep a high-score register that
// survives clear and is only zeroed by reset. Without it, hiscore is tied to 0.
//
// Parameters:
//   DIGITS        number of BCD digits, 1..8
//   BONUS_STREAK  consecutive hits before each hit scores 2, 1..15
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-low
//   hit        in   hit level; rising edge = one hit event
//   miss       in   miss level; rising edge = one miss event
//   clear      in   synchronous new-round clear, active-high (hiscore kept)
//   score      out  packed BCD score, digit 0 (units) in [3:0]
//   bonus      out  high while the streak has reached BONUS_STREAK
//   saturated  out  sticky overflow flag
//   hiscore    out  packed BCD high score (0 when SCORE_HISCORE_EN undefined)

module bcd_score_counter #(
    parameter int unsigned DIGITS       = 2,
    parameter int unsigned BONUS_STREAK = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                hit,
    input  logic                miss,
    input  logic                clear,
    output logic [4*DIGITS-1:0] score,
    output logic                bonus,
    output logic                saturated,
    output logic [4*DIGITS-1:0] hiscore
);

    localparam int unsigned W          = 4 * DIGITS;
    localparam logic [3:0]  STREAK_MAX = 4'(BONUS_STREAK);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic         hit_q;
    logic         miss_q;
    logic         hit_ev;
    logic         miss_ev;
    logic [3:0]   streak;
    logic [3:0]   streak_nxt;
    logic [W-1:0] score_nxt;
    logic [W-1:0] sum_v;
    logic [W-1:0] diff_v;
    logic         carry_out;
    logic         sat_nxt;
    logic         bonus_nxt;
    logic [1:0]   inc;

    // Ripple BCD add of a small increment (1 or 2); MSB of the result is the
    // carry out of the top digit.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a,
                                           input logic [1:0]   step);
        logic [W-1:0] r;
        logic [4:0]   d;
        logic [1:0]   c;
        r = a;
        c = step;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = {1'b0, a[4*i +: 4]} + {3'b000, c};
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                c           = 2'd1;
            end else begin
                r[4*i +: 4] = d[3:0];
                c           = 2'd0;
            end
        end
        return {(c != 2'd0), r};
    endfunction

    // BCD decrement by one with borrow; zero stays zero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic         b;
        r = a;
        b = (a != '0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (a[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = a[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        hit_ev  = hit & ~hit_q;
        miss_ev = miss & ~miss_q;
        inc     = (streak == STREAK_MAX) ? 2'd2 : 2'd1;
        {carry_out, sum_v} = bcd_add(score, inc);
        diff_v  = bcd_dec(score);

        score_nxt  = score;
        streak_nxt = streak;
        sat_nxt    = saturated;

        if (clear) begin
            score_nxt  = '0;
            streak_nxt = '0;
            sat_nxt    = 1'b0;
        end else if (hit_ev && miss_ev) begin
            streak_nxt = '0;
        end else if (hit_ev) begin
            if (carry_out) begin
                score_nxt = ALL_NINES;
                sat_nxt   = 1'b1;
            end else begin
                score_nxt = sum_v;
            end
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + 4'd1;
        end else if (miss_ev) begin
            score_nxt  = diff_v;
            streak_nxt = '0;
        end

        bonus_nxt = (streak_nxt == STREAK_MAX);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            score     <= '0;
            streak    <= '0;
            bonus     <= 1'b0;
            saturated <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            score     <= score_nxt;
            streak    <= streak_nxt;
            bonus     <= bonus_nxt;
            saturated <= sat_nxt;
            hit_q     <= hit;
            miss_q    <= miss;
        end
    end

`ifdef SCORE_HISCORE_EN
    // Packed BCD compares correctly as unsigned binary.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hiscore <= '0;
        end else if (score_nxt > hiscore) begin
            hiscore <= score_nxt;
        end
    end
`else
    assign hiscore = '0;
`endif

endmodule
